// File: rtl/mem_lane_scheduler.sv
// mem_lane_scheduler
//   Shares one single-ported data memory between the two M-stage lanes
//   (M1 older, M2 younger) of a dual-issue core. A lone request passes
//   straight through; two requests are serialised over two cycles in
//   program order, with a one-cycle pipeline stall.
//   Optional feature: define MEM_PERF_CNT_EN to build the dual-access
//   conflict counter on ConflictCount (otherwise it is tied to zero).
module mem_lane_scheduler #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReqM1,
    input  logic                  MemReqM2,
    input  logic                  MemWriteM1,
    input  logic                  MemWriteM2,
    input  logic [ADDR_WIDTH-1:0] AddrM1,
    input  logic [ADDR_WIDTH-1:0] AddrM2,
    input  logic [DATA_WIDTH-1:0] WriteDataM1,
    input  logic [DATA_WIDTH-1:0] WriteDataM2,
    input  logic [2:0]            AddrCtlM1,
    input  logic [2:0]            AddrCtlM2,
    output logic                  PortEn,
    output logic                  PortWE,
    output logic [ADDR_WIDTH-1:0] PortA,
    output logic [DATA_WIDTH-1:0] PortWD,
    output logic [2:0]            PortAC,
    input  logic [DATA_WIDTH-1:0] PortRD,
    output logic [DATA_WIDTH-1:0] ReadDataM1,
    output logic [DATA_WIDTH-1:0] ReadDataM2,
    output logic                  StallM,
    output logic [CNT_WIDTH-1:0]  ConflictCount
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    // Lane-2 access parked for the second cycle, plus lane-1 load result.
    logic                    l2_req_q;
    logic                    l2_we_q;
    logic [ADDR_WIDTH-1:0]   l2_a_q;
    logic [DATA_WIDTH-1:0]   l2_wd_q;
    logic [2:0]              l2_ac_q;
    logic [DATA_WIDTH-1:0]   rd1_q;

    logic                    dual;
    logic                    start_dual;

    assign dual       = MemReqM1 & MemReqM2;
    assign start_dual = (state_q == IDLE) & dual;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture lane-1 read data and park lane-2 fields when a dual access starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l2_req_q <= 1'b0;
            l2_we_q  <= 1'b0;
            l2_a_q   <= '0;
            l2_wd_q  <= '0;
            l2_ac_q  <= '0;
            rd1_q    <= '0;
        end else if (start_dual) begin
            l2_req_q <= MemReqM2;
            l2_we_q  <= MemWriteM2;
            l2_a_q   <= AddrM2;
            l2_wd_q  <= WriteDataM2;
            l2_ac_q  <= AddrCtlM2;
            rd1_q    <= PortRD;
        end
    end

    // Port steering, read-data return, stall and next-state decode.
    always_comb begin
        state_d    = state_q;
        PortEn     = 1'b0;
        PortWE     = 1'b0;
        PortA      = '0;
        PortWD     = '0;
        PortAC     = '0;
        ReadDataM1 = '0;
        ReadDataM2 = '0;
        StallM     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (MemReqM1) begin
                    // Lane 1 is older, so it always owns the first cycle.
                    PortEn     = 1'b1;
                    PortWE     = MemWriteM1;
                    PortA      = AddrM1;
                    PortWD     = WriteDataM1;
                    PortAC     = AddrCtlM1;
                    ReadDataM1 = PortRD;
                    if (MemReqM2) begin
                        StallM  = 1'b1;
                        state_d = SECOND;
                    end
                end else if (MemReqM2) begin
                    PortEn     = 1'b1;
                    PortWE     = MemWriteM2;
                    PortA      = AddrM2;
                    PortWD     = WriteDataM2;
                    PortAC     = AddrCtlM2;
                    ReadDataM2 = PortRD;
                end
            end
            SECOND: begin
                // Live lane inputs are ignored; only the parked lane-2 access runs.
                PortEn     = l2_req_q;
                PortWE     = l2_req_q & l2_we_q;
                PortA      = l2_a_q;
                PortWD     = l2_wd_q;
                PortAC     = l2_ac_q;
                ReadDataM1 = rd1_q;
                ReadDataM2 = PortRD;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset must never leak a memory access or a stall, even combinationally.
        if (rst) begin
            PortEn = 1'b0;
            PortWE = 1'b0;
            StallM = 1'b0;
        end
    end

`ifdef MEM_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] conflict_q;

    // Count each IDLE->SECOND transition; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= '0;
        end else if (start_dual) begin
            conflict_q <= conflict_q + CNT_WIDTH'(1);
        end
    end

    assign ConflictCount = conflict_q;
`else
    assign ConflictCount = '0;
`endif

    // SECOND is only ever entered with a parked lane-2 request.
    second_has_req: assert property (@(posedge clk) disable iff (rst)
        (state_q == SECOND) |-> l2_req_q);

endmodule

// File: tb/tb_mem_lane_scheduler.sv
// tb_mem_lane_scheduler
//   Scoreboarded bench: a program-order reference memory supplies expected
//   load data, queued when a load is issued and popped when the lane's
//   ReadData becomes valid. A second instance with CNT_WIDTH=2 shares the
//   inputs so counter wrap can be observed when MEM_PERF_CNT_EN is defined.
module tb_mem_lane_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReqM1, MemReqM2, MemWriteM1, MemWriteM2;
    logic [31:0] AddrM1, AddrM2, WriteDataM1, WriteDataM2;
    logic [2:0]  AddrCtlM1, AddrCtlM2;
    logic        PortEn, PortWE, StallM;
    logic [31:0] PortA, PortWD, PortRD, ReadDataM1, ReadDataM2, ConflictCount;
    logic [2:0]  PortAC;

    logic        p2_en, p2_we, p2_stall;
    logic [31:0] p2_a, p2_wd, p2_rd1, p2_rd2;
    logic [2:0]  p2_ac;
    logic [1:0]  p2_cnt;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] rd_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cnt_model = 0;
    logic [31:0] e1, e2;

    always #5 clk = ~clk;

    mem_lane_scheduler #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst),
        .MemReqM1(MemReqM1), .MemReqM2(MemReqM2),
        .MemWriteM1(MemWriteM1), .MemWriteM2(MemWriteM2),
        .AddrM1(AddrM1), .AddrM2(AddrM2),
        .WriteDataM1(WriteDataM1), .WriteDataM2(WriteDataM2),
        .AddrCtlM1(AddrCtlM1), .AddrCtlM2(AddrCtlM2),
        .PortEn(PortEn), .PortWE(PortWE), .PortA(PortA), .PortWD(PortWD),
        .PortAC(PortAC), .PortRD(PortRD),
        .ReadDataM1(ReadDataM1), .ReadDataM2(ReadDataM2),
        .StallM(StallM), .ConflictCount(ConflictCount)
    );

    mem_lane_scheduler #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .MemReqM1(MemReqM1), .MemReqM2(MemReqM2),
        .MemWriteM1(MemWriteM1), .MemWriteM2(MemWriteM2),
        .AddrM1(AddrM1), .AddrM2(AddrM2),
        .WriteDataM1(WriteDataM1), .WriteDataM2(WriteDataM2),
        .AddrCtlM1(AddrCtlM1), .AddrCtlM2(AddrCtlM2),
        .PortEn(p2_en), .PortWE(p2_we), .PortA(p2_a), .PortWD(p2_wd),
        .PortAC(p2_ac), .PortRD(PortRD),
        .ReadDataM1(p2_rd1), .ReadDataM2(p2_rd2),
        .StallM(p2_stall), .ConflictCount(p2_cnt)
    );

    // Word-addressed memory behind the port; combinational read, clocked write.
    assign PortRD = mem[PortA[7:2]];
    always @(posedge clk) begin
        if (PortEn && PortWE) mem[PortA[7:2]] <= PortWD;
    end

    function automatic logic [31:0] expected_count();
`ifdef MEM_PERF_CNT_EN
        return 32'(cnt_model);
`else
        return 32'd0;
`endif
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r1, input logic w1, input logic [31:0] a1,
                         input logic [31:0] d1, input logic [2:0] c1,
                         input logic r2, input logic w2, input logic [31:0] a2,
                         input logic [31:0] d2, input logic [2:0] c2);
        MemReqM1 = r1; MemWriteM1 = w1; AddrM1 = a1; WriteDataM1 = d1; AddrCtlM1 = c1;
        MemReqM2 = r2; MemWriteM2 = w2; AddrM2 = a2; WriteDataM2 = d2; AddrCtlM2 = c2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 32'h70, 32'hFFFF_FFFF, 3'd2, 1, 1, 32'h74, 32'hEEEE_EEEE, 3'd2);
        #2;
        checks++; if (PortEn !== 1'b0) begin errors++; $display("FAIL rst_porten got %0b want 0", PortEn); end
        checks++; if (PortWE !== 1'b0) begin errors++; $display("FAIL rst_portwe got %0b want 0", PortWE); end
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", StallM); end
        @(negedge clk);
        rst = 1'b0;
        idle();
        cnt_model = 0;
        #1;
        checks++; if (PortEn !== 1'b0) begin errors++; $display("FAIL idle_porten got %0b want 0", PortEn); end
        checks++; if (ReadDataM1 !== 32'd0 || ReadDataM2 !== 32'd0) begin
            errors++; $display("FAIL idle_rdata got %h/%h want 0/0", ReadDataM1, ReadDataM2); end
        checks++; if (ConflictCount !== 32'd0) begin errors++; $display("FAIL rst_count got %0d want 0", ConflictCount); end
    endtask

    task automatic test_single();
        next_cycle();
        drive(1, 0, 32'h10, 0, 3'd2, 0, 0, 0, 0, 0);
        rd_q.push_back(ref_mem[4]);
        @(negedge clk);
        checks++; if (PortEn !== 1'b1 || PortWE !== 1'b0) begin
            errors++; $display("FAIL m1_load_en got en=%0b we=%0b want 1/0", PortEn, PortWE); end
        checks++; if (PortA !== 32'h10) begin errors++; $display("FAIL m1_load_addr got %h want 00000010", PortA); end
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL m1_load_stall got %0b want 0", StallM); end
        e1 = rd_q.pop_front();
        checks++; if (ReadDataM1 !== e1) begin errors++; $display("FAIL m1_load_data got %h want %h", ReadDataM1, e1); end
        checks++; if (ReadDataM2 !== 32'd0) begin errors++; $display("FAIL m1_load_other got %h want 0", ReadDataM2); end

        next_cycle();
        drive(0, 0, 0, 0, 0, 1, 1, 32'h50, 32'h1234_5678, 3'd1);
        ref_mem[20] = 32'h1234_5678;
        @(negedge clk);
        checks++; if (PortEn !== 1'b1 || PortWE !== 1'b1 || PortA !== 32'h50) begin
            errors++; $display("FAIL m2_store_port got en=%0b we=%0b a=%h want 1/1/00000050", PortEn, PortWE, PortA); end
        checks++; if (PortWD !== 32'h1234_5678 || PortAC !== 3'd1) begin
            errors++; $display("FAIL m2_store_wd got %h ac=%0d want 12345678 ac=1", PortWD, PortAC); end

        next_cycle();
        drive(0, 0, 0, 0, 0, 1, 0, 32'h50, 0, 3'd5);
        rd_q.push_back(ref_mem[20]);
        @(negedge clk);
        e2 = rd_q.pop_front();
        checks++; if (ReadDataM2 !== e2) begin errors++; $display("FAIL m2_load_data got %h want %h", ReadDataM2, e2); end
        checks++; if (ReadDataM1 !== 32'd0 || PortAC !== 3'd5) begin
            errors++; $display("FAIL m2_load_other got rd1=%h ac=%0d want 0 ac=5", ReadDataM1, PortAC); end
    endtask

    task automatic test_store_load();
        next_cycle();
        drive(1, 1, 32'h20, 32'h1122_3344, 3'd2, 1, 0, 32'h20, 0, 3'd4);
        ref_mem[8] = 32'h1122_3344;
        rd_q.push_back(ref_mem[8]);
        cnt_model++;
        @(negedge clk);
        checks++; if (StallM !== 1'b1 || PortWE !== 1'b1) begin
            errors++; $display("FAIL st_ld_c0 got stall=%0b we=%0b want 1/1", StallM, PortWE); end
        checks++; if (PortA !== 32'h20 || PortWD !== 32'h1122_3344 || PortAC !== 3'd2) begin
            errors++; $display("FAIL st_ld_c0_port got a=%h wd=%h ac=%0d want 00000020/11223344/2", PortA, PortWD, PortAC); end
        next_cycle();
        // Live inputs change during SECOND and must be ignored.
        drive(1, 1, 32'h24, 32'h0000_0BAD, 3'd0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (PortA !== 32'h20 || PortWE !== 1'b0 || PortAC !== 3'd4 || StallM !== 1'b0) begin
            errors++; $display("FAIL st_ld_c1_port got a=%h we=%0b ac=%0d stall=%0b want 00000020/0/4/0", PortA, PortWE, PortAC, StallM); end
        e2 = rd_q.pop_front();
        checks++; if (ReadDataM2 !== e2) begin errors++; $display("FAIL st_ld_c1_data got %h want %h", ReadDataM2, e2); end
        next_cycle();
        drive(1, 0, 32'h24, 0, 3'd2, 0, 0, 0, 0, 0);
        rd_q.push_back(ref_mem[9]);
        @(negedge clk);
        e1 = rd_q.pop_front();
        checks++; if (ReadDataM1 !== e1) begin errors++; $display("FAIL second_ignores_inputs got %h want %h", ReadDataM1, e1); end
    endtask

    task automatic test_two_stores();
        next_cycle();
        drive(1, 1, 32'h30, 32'hAAAA_0000, 3'd2, 1, 1, 32'h30, 32'h0000_BBBB, 3'd2);
        ref_mem[12] = 32'hAAAA_0000;
        ref_mem[12] = 32'h0000_BBBB;
        cnt_model++;
        @(negedge clk);
        checks++; if (StallM !== 1'b1 || PortWE !== 1'b1 || PortWD !== 32'hAAAA_0000) begin
            errors++; $display("FAIL st_st_c0 got stall=%0b we=%0b wd=%h want 1/1/aaaa0000", StallM, PortWE, PortWD); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (PortWE !== 1'b1 || PortWD !== 32'h0000_BBBB || PortA !== 32'h30) begin
            errors++; $display("FAIL st_st_c1 got we=%0b wd=%h a=%h want 1/0000bbbb/00000030", PortWE, PortWD, PortA); end
        next_cycle();
        drive(1, 0, 32'h30, 0, 3'd2, 0, 0, 0, 0, 0);
        rd_q.push_back(ref_mem[12]);
        @(negedge clk);
        e1 = rd_q.pop_front();
        checks++; if (ReadDataM1 !== e1) begin errors++; $display("FAIL st_st_final got %h want %h", ReadDataM1, e1); end
    endtask

    task automatic test_two_loads();
        next_cycle();
        drive(1, 0, 32'h40, 0, 3'd2, 1, 0, 32'h44, 0, 3'd2);
        rd_q.push_back(ref_mem[16]);
        rd_q.push_back(ref_mem[17]);
        cnt_model++;
        e1 = rd_q.pop_front();
        e2 = rd_q.pop_front();
        @(negedge clk);
        checks++; if (ReadDataM1 !== e1 || ReadDataM2 !== 32'd0) begin
            errors++; $display("FAIL ld_ld_c0 got %h/%h want %h/0", ReadDataM1, ReadDataM2, e1); end
        next_cycle();
        drive(1, 0, 32'h10, 0, 3'd2, 1, 0, 32'h10, 0, 3'd2);
        @(negedge clk);
        checks++; if (ReadDataM1 !== e1) begin errors++; $display("FAIL ld_ld_captured got %h want %h", ReadDataM1, e1); end
        checks++; if (ReadDataM2 !== e2 || StallM !== 1'b0) begin
            errors++; $display("FAIL ld_ld_c1 got %h stall=%0b want %h stall=0", ReadDataM2, StallM, e2); end
    endtask

    task automatic test_load_store();
        next_cycle();
        drive(1, 0, 32'h10, 0, 3'd2, 1, 1, 32'h10, 32'hCAFE_F00D, 3'd2);
        rd_q.push_back(ref_mem[4]);
        ref_mem[4] = 32'hCAFE_F00D;
        cnt_model++;
        e1 = rd_q.pop_front();
        @(negedge clk);
        checks++; if (ReadDataM1 !== e1) begin errors++; $display("FAIL ld_st_old got %h want %h", ReadDataM1, e1); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (ReadDataM1 !== e1 || PortWE !== 1'b1) begin
            errors++; $display("FAIL ld_st_c1 got rd1=%h we=%0b want %h/1", ReadDataM1, PortWE, e1); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 1, 0, 32'h10, 0, 3'd2);
        rd_q.push_back(ref_mem[4]);
        @(negedge clk);
        e2 = rd_q.pop_front();
        checks++; if (ReadDataM2 !== e2) begin errors++; $display("FAIL ld_st_new got %h want %h", ReadDataM2, e2); end
    endtask

    task automatic test_reset_in_second();
        next_cycle();
        drive(1, 0, 32'h60, 0, 3'd2, 1, 1, 32'h64, 32'h9999_9999, 3'd2);
        cnt_model++;
        @(negedge clk);
        checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL rs_c0_stall got %0b want 1", StallM); end
        next_cycle();
        idle();
        rst = 1'b1;
        cnt_model = 0;
        #1;
        checks++; if (PortEn !== 1'b0 || PortWE !== 1'b0 || StallM !== 1'b0) begin
            errors++; $display("FAIL rs_outputs got en=%0b we=%0b stall=%0b want 0/0/0", PortEn, PortWE, StallM); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        drive(1, 0, 32'h64, 0, 3'd2, 0, 0, 0, 0, 0);
        rd_q.push_back(ref_mem[25]);
        @(negedge clk);
        checks++; if (PortA !== 32'h64 || StallM !== 1'b0) begin
            errors++; $display("FAIL rs_idle got a=%h stall=%0b want 00000064/0", PortA, StallM); end
        e1 = rd_q.pop_front();
        checks++; if (ReadDataM1 !== e1) begin errors++; $display("FAIL rs_no_write got %h want %h", ReadDataM1, e1); end
        checks++; if (ConflictCount !== expected_count()) begin
            errors++; $display("FAIL rs_count got %0d want %0d", ConflictCount, expected_count()); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(1, 0, 32'h40, 0, 3'd2, 1, 0, 32'h44, 0, 3'd2);
            rd_q.push_back(ref_mem[16]);
            rd_q.push_back(ref_mem[17]);
            cnt_model++;
            e1 = rd_q.pop_front();
            e2 = rd_q.pop_front();
            @(negedge clk);
            checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL b2b_stall%0d got %0b want 1", i, StallM); end
            next_cycle();
            @(negedge clk);
            checks++; if (StallM !== 1'b0 || ReadDataM1 !== e1 || ReadDataM2 !== e2) begin
                errors++; $display("FAIL b2b_second%0d got stall=%0b %h/%h want 0 %h/%h", i, StallM, ReadDataM1, ReadDataM2, e1, e2); end
        end
        checks++; if (ConflictCount !== expected_count()) begin
            errors++; $display("FAIL b2b_count got %0d want %0d", ConflictCount, expected_count()); end
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            drive(1, 0, 32'h80, 0, 3'd2, 1, 0, 32'h84, 0, 3'd2);
            cnt_model++;
            next_cycle();
        end
        idle();
        @(negedge clk);
        checks++; if (ConflictCount !== expected_count()) begin
            errors++; $display("FAIL wrap_count32 got %0d want %0d", ConflictCount, expected_count()); end
        e1 = expected_count();
        checks++; if (p2_cnt !== e1[1:0]) begin
            errors++; $display("FAIL wrap_count2 got %0d want %0d", p2_cnt, e1[1:0]); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        mem[4]  = 32'hDEAD_BEEF; ref_mem[4]  = 32'hDEAD_BEEF;
        mem[16] = 32'h0000_0005; ref_mem[16] = 32'h0000_0005;
        mem[17] = 32'h0000_0006; ref_mem[17] = 32'h0000_0006;
        idle();
        test_reset();
        test_single();
        test_store_load();
        test_two_stores();
        test_two_loads();
        test_load_store();
        test_reset_in_second();
        test_back_to_back();
        test_counter_wrap();
        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
